// File: rtl/logu_schraudolph_pipe_pkg.sv
// Shared types and format helpers for the Schraudolph log/exp units.
// Format geometry, class flags, the LN2 constant and canonical special
// encodings live here so the exp unit can reuse them.
package logu_schraudolph_pipe_pkg;

    typedef enum logic [1:0] {
        FP32,
        FP16,
        FP16ALT,
        FP8
    } fp_format_e;

    typedef struct packed {
        logic is_nan;
        logic is_neg;
        logic is_zero;
        logic is_inf;
    } logu_class_t;

    function automatic int fp_exp_bits(fp_format_e f);
        case (f)
            FP32:    return 8;
            FP16:    return 5;
            FP16ALT: return 8;
            default: return 5;
        endcase
    endfunction

    function automatic int fp_man_bits(fp_format_e f);
        case (f)
            FP32:    return 23;
            FP16:    return 10;
            FP16ALT: return 7;
            default: return 2;
        endcase
    endfunction

    function automatic int fp_width(fp_format_e f);
        return 1 + fp_exp_bits(f) + fp_man_bits(f);
    endfunction

    function automatic int fp_bias(fp_format_e f);
        return (1 << (fp_exp_bits(f) - 1)) - 1;
    endfunction

    // ln(2) as an unsigned Q0.bf integer, rounded to nearest
    function automatic int ln2_const(int bf);
        return int'(0.6931471805599453 * real'(1 << bf));
    endfunction

    function automatic logic [31:0] pinf_bits(fp_format_e f);
        return ((32'd1 << fp_exp_bits(f)) - 32'd1) << fp_man_bits(f);
    endfunction

    function automatic logic [31:0] ninf_bits(fp_format_e f);
        return pinf_bits(f) | (32'd1 << (fp_exp_bits(f) + fp_man_bits(f)));
    endfunction

    // quiet NaN: exponent all ones, mantissa MSB set, positive sign
    function automatic logic [31:0] qnan_bits(fp_format_e f);
        return pinf_bits(f) | (32'd1 << (fp_man_bits(f) - 1));
    endfunction

endpackage

// File: rtl/logu_schraudolph_pipe_if.sv
// Valid/ready stream carrying one FP operand/result plus a sideband tag.
interface logu_schraudolph_pipe_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;

    modport master (output valid, data, tag, input ready);
    modport slave  (input valid, data, tag, output ready);
endinterface

// File: rtl/logu_fix2fp.sv
// Combinational signed fixed-point to floating-point converter.
// Input carries FRAC fraction bits; output is {sign, exp, man}.
// Caller guarantees the result never overflows or goes subnormal.
module logu_fix2fp #(
    parameter int IW    = 31,
    parameter int FRAC  = 21,
    parameter int EXP   = 8,
    parameter int MAN   = 7,
    parameter int BIAS  = 127,
    parameter int ROUND = 1
) (
    input  logic signed [IW-1:0]  fix_i,
    output logic        [EXP+MAN:0] fp_o
);
    localparam int LZW = $clog2(IW + 1);

    logic           sign;
    logic [IW-1:0]  mag;
    logic [IW-1:0]  norm;
    logic [LZW-1:0] lz;
    logic [MAN-1:0] man;
    logic [MAN-1:0] man_r;
    logic           guard;
    logic           sticky;
    logic           rnd;
    logic           carry;
    int             exp_v;

    // magnitude and leading-zero count (highest set bit wins)
    always_comb begin
        sign = fix_i[IW-1];
        mag  = sign ? -fix_i : fix_i;
        lz   = LZW'(IW);
        for (int i = 0; i < IW; i++) begin
            if (mag[i]) lz = LZW'(IW - 1 - i);
        end
    end

    // normalize so the leading one sits at the top, then round and pack;
    // a zero input leaves norm[IW-1] clear and packs to +0
    always_comb begin
        norm   = mag << lz;
        man    = norm[IW-2 -: MAN];
        guard  = norm[IW-2-MAN];
        sticky = |norm[IW-3-MAN:0];
        rnd    = (ROUND != 0) && guard && (sticky || man[0]);
        {carry, man_r} = {1'b0, man} + (MAN+1)'(rnd);
        exp_v  = BIAS + IW - 1 - FRAC - int'(lz) + int'(carry);
        fp_o   = norm[IW-1] ? {sign, EXP'(exp_v), man_r} : '0;
    end
endmodule

// File: rtl/logu_schraudolph_pipe.sv
// Three-stage Schraudolph natural-log approximation.
// S1 decodes the operand as fixed-point log2, S2 scales by ln2,
// S3 converts back to float and applies special-case overrides.
// Elastic valid/ready pipeline: full throughput, backpressure, no skid.
module logu_schraudolph_pipe
    import logu_schraudolph_pipe_pkg::*;
#(
    parameter fp_format_e FPFORMAT        = FP16ALT,
    parameter int         B_FRACTION      = 14,
    parameter int         ENABLE_ROUNDING = 1,
    parameter int         TAG_WIDTH       = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    logu_schraudolph_pipe_if.slave         in_if,
    logu_schraudolph_pipe_if.master        out_if
);
    localparam int EXP    = fp_exp_bits(FPFORMAT);
    localparam int MAN    = fp_man_bits(FPFORMAT);
    localparam int W      = fp_width(FPFORMAT);
    localparam int BIAS   = fp_bias(FPFORMAT);
    localparam int LW     = B_FRACTION + 1;
    localparam int PW     = W + LW;
    localparam int STAGES = 3;

    localparam logic signed [LW-1:0] LN2   = LW'(ln2_const(B_FRACTION));
    localparam logic signed [W-1:0]  L_OFS = W'(BIAS << MAN);
    localparam logic [W-1:0]         QNAN  = W'(qnan_bits(FPFORMAT));
    localparam logic [W-1:0]         PINF  = W'(pinf_bits(FPFORMAT));
    localparam logic [W-1:0]         NINF  = W'(ninf_bits(FPFORMAT));

    logic [STAGES:1]        vld_pipe_q, vld_pipe_d, en;
    logic [EXP-1:0]         op_exp;
    logic [MAN-1:0]         op_man;
    logu_class_t            cls_in, s1_cls_q, s1_cls_d, s2_cls_q, s2_cls_d;
    logic signed [W-1:0]    l_in, s1_l_q, s1_l_d;
    logic signed [PW-1:0]   p_s2, s2_p_q, s2_p_d;
    logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, s3_tag_q, s3_tag_d;
    logic [W-1:0]           fix_res, pack_res, s3_res_q, s3_res_d;

    // a stage may load when empty or when its contents move on this cycle
    always_comb begin
        en[3] = !vld_pipe_q[3] || out_if.ready;
        en[2] = !vld_pipe_q[2] || en[3];
        en[1] = !vld_pipe_q[1] || en[2];
    end

    assign in_if.ready  = en[1];
    assign out_if.valid = vld_pipe_q[3];
    assign out_if.data  = s3_res_q;
    assign out_if.tag   = s3_tag_q;

    // S1 decode: class flags and the operand reinterpreted as signed log2
    always_comb begin
        op_exp         = in_if.data[W-2 -: EXP];
        op_man         = in_if.data[MAN-1:0];
        cls_in.is_zero = (op_exp == '0);
        cls_in.is_nan  = (op_exp == '1) && (op_man != '0);
        cls_in.is_inf  = (op_exp == '1) && (op_man == '0);
        cls_in.is_neg  = in_if.data[W-1] && !cls_in.is_zero;
        l_in           = signed'({1'b0, in_if.data[W-2:0]}) - L_OFS;
    end

    // S2 scale: full-precision product, no truncation
    assign p_s2 = PW'(s1_l_q) * PW'(LN2);

    logu_fix2fp #(
        .IW    (PW),
        .FRAC  (MAN + B_FRACTION),
        .EXP   (EXP),
        .MAN   (MAN),
        .BIAS  (BIAS),
        .ROUND (ENABLE_ROUNDING)
    ) u_fix2fp (
        .fix_i (s2_p_q),
        .fp_o  (fix_res)
    );

    // S3 special-case override in priority order
    always_comb begin
        if (s2_cls_q.is_nan)       pack_res = QNAN;
        else if (s2_cls_q.is_neg)  pack_res = QNAN;
        else if (s2_cls_q.is_zero) pack_res = NINF;
        else if (s2_cls_q.is_inf)  pack_res = PINF;
        else                       pack_res = fix_res;
    end

    // next-state: clear flushes everything, otherwise each stage loads on its enable
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_cls_d   = s1_cls_q;
        s1_l_d     = s1_l_q;
        s1_tag_d   = s1_tag_q;
        s2_cls_d   = s2_cls_q;
        s2_p_d     = s2_p_q;
        s2_tag_d   = s2_tag_q;
        s3_res_d   = s3_res_q;
        s3_tag_d   = s3_tag_q;
        if (clear_i) begin
            vld_pipe_d = '0;
            s1_cls_d   = '0;
            s1_l_d     = '0;
            s1_tag_d   = '0;
            s2_cls_d   = '0;
            s2_p_d     = '0;
            s2_tag_d   = '0;
            s3_res_d   = '0;
            s3_tag_d   = '0;
        end else begin
            if (en[1]) begin
                vld_pipe_d[1] = in_if.valid;
                s1_cls_d      = cls_in;
                s1_l_d        = l_in;
                s1_tag_d      = in_if.tag;
            end
            if (en[2]) begin
                vld_pipe_d[2] = vld_pipe_q[1];
                s2_cls_d      = s1_cls_q;
                s2_p_d        = p_s2;
                s2_tag_d      = s1_tag_q;
            end
            if (en[3]) begin
                vld_pipe_d[3] = vld_pipe_q[2];
                s3_res_d      = pack_res;
                s3_tag_d      = s2_tag_q;
            end
        end
    end

    // pipeline registers, async reset discards in-flight operands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            s1_cls_q   <= '0;
            s1_l_q     <= '0;
            s1_tag_q   <= '0;
            s2_cls_q   <= '0;
            s2_p_q     <= '0;
            s2_tag_q   <= '0;
            s3_res_q   <= '0;
            s3_tag_q   <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_cls_q   <= s1_cls_d;
            s1_l_q     <= s1_l_d;
            s1_tag_q   <= s1_tag_d;
            s2_cls_q   <= s2_cls_d;
            s2_p_q     <= s2_p_d;
            s2_tag_q   <= s2_tag_d;
            s3_res_q   <= s3_res_d;
            s3_tag_q   <= s3_tag_d;
        end
    end
endmodule

// File: tb/tb_logu_schraudolph_pipe.sv
// Bench for logu_schraudolph_pipe (bf16, B_FRACTION=14, rounding on).
// Scoreboard queue filled when an operand is accepted, drained by a
// monitor on the falling edge; reference model goes through a double.
module tb_logu_schraudolph_pipe;

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    int   checks   = 0;
    int   errors   = 0;
    int   n_out    = 0;
    int   accepted = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logu_schraudolph_pipe_if #(.DATA_W(16), .TAG_W(4)) in_if ();
    logu_schraudolph_pipe_if #(.DATA_W(16), .TAG_W(4)) out_if ();

    logu_schraudolph_pipe dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .in_if   (in_if),
        .out_if  (out_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // reference: ln(x) = ln2 * (bits - 127<<7), scaled value rebuilt via a double
    function automatic logic [15:0] ref_ln(input logic [15:0] op);
        int          e;
        int          m;
        int          be;
        longint      p;
        real         r;
        logic [63:0] b;
        logic [6:0]  mn;
        logic        g;
        logic        st;
        e = int'(op[14:7]);
        m = int'(op[6:0]);
        if (e == 255 && m != 0) return 16'h7FC0;
        if (op[15] && e != 0)   return 16'h7FC0;
        if (e == 0)             return 16'hFF80;
        if (e == 255)           return 16'h7F80;
        p = longint'(int'(op[14:0]) - 16256) * longint'(11357);
        if (p == 0) return 16'h0000;
        r  = real'(p) / 2097152.0;
        b  = $realtobits(r);
        be = int'(b[62:52]) - 1023 + 127;
        mn = b[51:45];
        g  = b[44];
        st = |b[43:0];
        if (g && (st || mn[0])) begin
            if (mn == 7'h7F) begin
                mn = 7'h00;
                be++;
            end else begin
                mn = mn + 7'd1;
            end
        end
        return {b[63], 8'(be), mn};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 3) != 0) r[15] = 1'b0;
        return r;
    endfunction

    // offer one operand until accepted; expectation queued at the accepting edge
    task automatic send(input logic [15:0] op, input logic [3:0] tg, input logic [15:0] ex);
        bit done;
        exp_t e;
        done = 0;
        in_if.valid = 1'b1;
        in_if.data  = op;
        in_if.tag   = tg;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_if.ready) begin
                e.res = ex;
                e.tag = tg;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                accepted++;
                done = 1;
            end
        end
        in_if.valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
        chk(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // monitor: compare every accepted result against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_if.valid && out_if.ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {12'h0, out_if.tag, out_if.data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_res", out_if.data, e.res);
                    chk("out_tag", out_if.tag, e.tag);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   base;
        int   t0;
        logic [15:0] op;
        exp_t e;

        tbl[0] = '{16'h3F80, 16'h0000};
        tbl[1] = '{16'h4000, 16'h3F31};
        tbl[2] = '{16'h3F00, 16'hBF31};
        tbl[3] = '{16'h402E, 16'h3F71};
        tbl[4] = '{16'h0000, 16'hFF80};
        tbl[5] = '{16'h0001, 16'hFF80};
        tbl[6] = '{16'hBF80, 16'h7FC0};
        tbl[7] = '{16'h7F80, 16'h7F80};
        tbl[8] = '{16'h7FC1, 16'h7FC0};
        tbl[9] = '{16'h8000, 16'hFF80};

        rst          = 1'b0;
        clear        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.tag    = '0;
        out_if.ready = 1'b1;
        #2 rst = 1'b1;
        #2;
        chk("reset_valid", out_if.valid, 0);
        chk("reset_res", out_if.data, 0);
        chk("reset_tag", out_if.tag, 0);
        chk("reset_ready", in_if.ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1.0 -> +0 exactly three cycles after being presented
        in_if.valid = 1'b1;
        in_if.data  = 16'h3F80;
        in_if.tag   = 4'h5;
        e.res = 16'h0000;
        e.tag = 4'h5;
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_if.valid = 1'b0;
        @(negedge clk) chk("lat_edge1", out_if.valid, 0);
        @(negedge clk) chk("lat_edge2", out_if.valid, 0);
        @(negedge clk) chk("lat_edge3", out_if.valid, 1);
        @(posedge clk);
        #1;

        // table of fixed vectors, back to back
        for (int i = 0; i < 10; i++) send(tbl[i].op, 4'(i), tbl[i].res);
        drain("table_drain");

        // backpressure: five offered with ready_i low
        out_if.ready = 1'b0;
        accepted = 0;
        base = n_out;
        fork
            begin
                send(16'h4000, 4'd1, 16'h3F31);
                send(16'h3F00, 4'd2, 16'hBF31);
                send(16'h402E, 4'd3, 16'h3F71);
                send(16'h7F80, 4'd4, 16'h7F80);
                send(16'h3F80, 4'd5, 16'h0000);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_ready", in_if.ready, 0);
                    chk("bp_valid", out_if.valid, 1);
                    chk("bp_res_hold", out_if.data, 16'h3F31);
                    chk("bp_tag_hold", out_if.tag, 1);
                end
                chk("bp_accepted", accepted, 3);
                chk("bp_none_out", n_out - base, 0);
                @(posedge clk);
                #1 out_if.ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_count", n_out - base, 5);

        // random stream under random backpressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    op = rand_op();
                    send(op, 4'(i), ref_ln(op));
                end
            end
            begin
                for (int k = 0; k < 150; k++) begin
                    @(posedge clk);
                    #1 out_if.ready = ($urandom_range(0, 2) != 0);
                end
                out_if.ready = 1'b1;
            end
        join
        out_if.ready = 1'b1;
        drain("rbp_drain");

        // clear with two in flight plus one offered in the clear cycle
        base = n_out;
        in_if.valid = 1'b1;
        in_if.data  = 16'h4000;
        in_if.tag   = 4'hA;
        @(posedge clk);
        #1;
        in_if.data  = 16'h3F00;
        in_if.tag   = 4'hB;
        @(posedge clk);
        #1;
        in_if.data  = 16'h402E;
        in_if.tag   = 4'hC;
        clear       = 1'b1;
        @(posedge clk);
        #1;
        clear       = 1'b0;
        in_if.valid = 1'b0;
        @(negedge clk);
        chk("clr_valid", out_if.valid, 0);
        chk("clr_res", out_if.data, 0);
        repeat (4) @(negedge clk) chk("clr_quiet", out_if.valid, 0);
        chk("clr_no_out", n_out - base, 0);
        @(posedge clk);
        #1;
        in_if.valid = 1'b1;
        in_if.data  = 16'h7FC1;
        in_if.tag   = 4'h9;
        e.res = 16'h7FC0;
        e.tag = 4'h9;
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_if.valid = 1'b0;
        @(negedge clk) chk("clr_lat1", out_if.valid, 0);
        @(negedge clk) chk("clr_lat2", out_if.valid, 0);
        @(negedge clk) chk("clr_lat3", out_if.valid, 1);
        drain("clr_drain");

        // asynchronous reset mid-stream
        send(16'h3F80, 4'd1, 16'h0000);
        send(16'h4000, 4'd2, 16'h3F31);
        send(16'h3F00, 4'd3, 16'hBF31);
        chk("arst_pre_valid", out_if.valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", out_if.valid, 0);
        chk("arst_res", out_if.data, 0);
        chk("arst_tag", out_if.tag, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // random stream, ready_i high: one accept per cycle, bit-exact results
        base = n_out;
        t0   = cyc;
        for (int i = 0; i < 200; i++) begin
            op = rand_op();
            send(op, 4'(i), ref_ln(op));
        end
        chk("rand_in_rate", cyc - t0, 200);
        drain("rand_drain");
        chk("rand_count", n_out - base, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
